// File: rtl/multicycle_cpu.sv
// multicycle_cpu
//   Four-state multicycle core (FETCH/DECODE/EXEC/WB, plus HALTED) that runs a
//   small MIPS-like subset: R-type add/sub/and/or/xor/nor/sltu/sllv and addi.
//   Opcode 0x3F stops the core until the next reset.
// Ports
//   CLK, RST_N        clock (posedge) and asynchronous active-low reset
//   IMEM_REQ/ADDR     fetch request and byte address (always the PC)
//   IMEM_RDY/DATA     fetch handshake and instruction word
//   ALU_OUT/OF/ZF     result and flags latched at the end of EXEC
//   RETIRE            one-cycle pulse in WB
//   HALT, DBG_STATE   halted status and raw FSM state code
module multicycle_cpu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_RDY,
    input  logic [31:0]       IMEM_DATA,
    output logic [DATA_W-1:0] ALU_OUT,
    output logic              ALU_OF,
    output logic              ALU_ZF,
    output logic              RETIRE,
    output logic              HALT,
    output logic [2:0]        DBG_STATE
);
    localparam int SH_W   = $clog2(DATA_W);
    localparam int NREG   = 2**REG_AW;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALTED = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [31:0]         ir_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [DATA_W-1:0]   alu_out_q;
    logic                alu_of_q, alu_zf_q;
    logic [DATA_W-1:0]   regs_q [NREG];

    // Instruction fields
    logic [5:0]          op, func;
    logic [REG_AW-1:0]   rs, rt, rd;
    logic [DATA_W-1:0]   imm;
    logic                unused_ir;

    assign op   = ir_q[31:26];
    assign func = ir_q[5:0];
    assign rs   = ir_q[21 +: REG_AW];
    assign rt   = ir_q[16 +: REG_AW];
    assign rd   = ir_q[11 +: REG_AW];
    assign imm  = DATA_W'($signed(ir_q[15:0]));
    assign unused_ir = ^ir_q;

    // Classification: anything not recognised becomes a flag-only no-op
    logic is_addi, is_r, r_ok, wr_en;
    logic [REG_AW-1:0] wr_idx;

    assign is_addi = (op == 6'h08);
    assign is_r    = (op == 6'h00);
    always_comb begin
        r_ok = 1'b0;
        case (func)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04: r_ok = 1'b1;
            default: r_ok = 1'b0;
        endcase
    end
    assign wr_en  = is_addi || (is_r && r_ok);
    assign wr_idx = is_addi ? rt : rd;

    // ALU
    logic [DATA_W-1:0] b_op, sum, diff, alu_res;
    logic              of_add, of_sub, alu_of;

    assign b_op   = is_addi ? imm : b_q;
    assign sum    = a_q + b_op;
    assign diff   = a_q - b_q;
    // Signed overflow: operands agree (add) / disagree (sub) in sign but the
    // result's sign differs from A.
    assign of_add = (a_q[DATA_W-1] == b_op[DATA_W-1]) && (sum[DATA_W-1]  != a_q[DATA_W-1]);
    assign of_sub = (a_q[DATA_W-1] != b_q[DATA_W-1])  && (diff[DATA_W-1] != a_q[DATA_W-1]);

    always_comb begin
        alu_res = sum;
        alu_of  = of_add;
        if (is_r && r_ok) begin
            alu_of = 1'b0;
            case (func)
                6'h20: begin alu_res = sum;  alu_of = of_add; end
                6'h22: begin alu_res = diff; alu_of = of_sub; end
                6'h24: alu_res = a_q & b_q;
                6'h25: alu_res = a_q | b_q;
                6'h26: alu_res = a_q ^ b_q;
                6'h27: alu_res = ~(a_q | b_q);
                6'h2B: begin alu_res = '0; alu_res[0] = (a_q < b_q); end
                6'h04: alu_res = b_q << a_q[SH_W-1:0];
                default: alu_res = sum;
            endcase
        end
        // addi and unrecognised encodings both take the add path above
    end

    // FSM
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (IMEM_RDY) state_d = S_DECODE;
            S_DECODE: state_d = (op == 6'h3F) ? S_HALTED : S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    // Datapath
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            alu_of_q  <= 1'b0;
            alu_zf_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (IMEM_RDY) ir_q <= IMEM_DATA;
                S_DECODE: begin
                    a_q <= (rs == '0) ? '0 : regs_q[rs];
                    b_q <= (rt == '0) ? '0 : regs_q[rt];
                end
                S_EXEC: begin
                    alu_out_q <= alu_res;
                    alu_of_q  <= alu_of;
                    alu_zf_q  <= (alu_res == '0);
                end
                S_WB: begin
                    if (wr_en && (wr_idx != '0)) regs_q[wr_idx] <= alu_out_q;
                    pc_q <= pc_q + ADDR_W'(4);
                end
                default: ;
            endcase
        end
    end

    // IMEM_REQ is gated by RST_N so it is low throughout reset.
    assign IMEM_REQ  = RST_N && (state_q == S_FETCH);
    assign IMEM_ADDR = pc_q;
    assign ALU_OUT   = alu_out_q;
    assign ALU_OF    = alu_of_q;
    assign ALU_ZF    = alu_zf_q;
    assign RETIRE    = (state_q == S_WB);
    assign HALT      = (state_q == S_HALTED);
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
module tb_multicycle_cpu;
    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Main core: default parameters
    logic        RST_N, IMEM_RDY, IMEM_REQ;
    logic [7:0]  IMEM_ADDR;
    logic [31:0] IMEM_DATA, ALU_OUT;
    logic        ALU_OF, ALU_ZF, RETIRE, HALT;
    logic [2:0]  DBG_STATE;
    logic [31:0] imem [0:63];

    assign IMEM_DATA = imem[IMEM_ADDR[7:2]];

    multicycle_cpu #(.DATA_W(32), .ADDR_W(8), .REG_AW(5)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_RDY(IMEM_RDY), .IMEM_DATA(IMEM_DATA), .ALU_OUT(ALU_OUT),
        .ALU_OF(ALU_OF), .ALU_ZF(ALU_ZF), .RETIRE(RETIRE), .HALT(HALT),
        .DBG_STATE(DBG_STATE)
    );

    // Small core: ADDR_W=4 for PC wrap
    logic        RST2_N, IMEM_REQ2, ALU_OF2, ALU_ZF2, RETIRE2, HALT2;
    logic [3:0]  IMEM_ADDR2;
    logic [31:0] ALU_OUT2;
    logic [2:0]  DBG_STATE2;

    multicycle_cpu #(.DATA_W(32), .ADDR_W(4), .REG_AW(5)) u_small (
        .CLK(CLK), .RST_N(RST2_N), .IMEM_REQ(IMEM_REQ2), .IMEM_ADDR(IMEM_ADDR2),
        .IMEM_RDY(1'b1), .IMEM_DATA(32'h20210001), .ALU_OUT(ALU_OUT2),
        .ALU_OF(ALU_OF2), .ALU_ZF(ALU_ZF2), .RETIRE(RETIRE2), .HALT(HALT2),
        .DBG_STATE(DBG_STATE2)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the sampling point of a FETCH cycle already 'start' cycles in.
    task automatic run_instr(input string tag, input int start, input int lat,
                             input logic [31:0] out, input logic of, input logic zf,
                             input logic [7:0] npc);
        int cyc;
        cyc = start;
        while (RETIRE !== 1'b1 && cyc < 30) begin
            @(negedge CLK); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_out"}, ALU_OUT, out);
        check({tag, "_of"}, {31'd0, ALU_OF}, {31'd0, of});
        check({tag, "_zf"}, {31'd0, ALU_ZF}, {31'd0, zf});
        @(negedge CLK); #1;
        check({tag, "_next_addr"}, {24'd0, IMEM_ADDR}, {24'd0, npc});
        check({tag, "_retire_low"}, {31'd0, RETIRE}, 32'd0);
    endtask

    initial begin
        RST_N = 1'b0; RST2_N = 1'b0; IMEM_RDY = 1'b1;
        for (int i = 0; i < 64; i++) imem[i] = 32'hFC000000;
        imem[0]  = 32'h20010005; // addi r1,r0,5
        imem[1]  = 32'h2001FFFF; // addi r1,r0,-1
        imem[2]  = 32'h00211020; // add  r2,r1,r1
        imem[3]  = 32'h0020182B; // sltu r3,r1,r0
        imem[4]  = 32'h20010001; // addi r1,r0,1
        imem[5]  = 32'h2004001F; // addi r4,r0,31
        imem[6]  = 32'h00811004; // sllv r2,r1,r4
        imem[7]  = 32'h00022822; // sub  r5,r0,r2
        imem[8]  = 32'h20000007; // addi r0,r0,7
        imem[9]  = 32'h00000820; // add  r1,r0,r0
        imem[10] = 32'h00221820; // add  r3,r1,r2   (fetched with stalls)
        imem[11] = 32'h04A31820; // op=1: no-op, flags from r5+r3
        imem[12] = 32'h00603020; // add  r6,r3,r0   (r3 untouched by no-op)
        imem[13] = 32'hFC000000; // halt

        repeat (2) @(negedge CLK);
        #1;
        check("rst_state", {29'd0, DBG_STATE}, 32'd0);
        check("rst_req", {31'd0, IMEM_REQ}, 32'd0);
        check("rst_addr", {24'd0, IMEM_ADDR}, 32'd0);
        check("rst_alu", ALU_OUT, 32'd0);
        check("rst_flags", {30'd0, ALU_OF, ALU_ZF}, 32'd0);
        check("rst_retire_halt", {30'd0, RETIRE, HALT}, 32'd0);

        @(negedge CLK); RST_N = 1'b1; #1;
        check("req_after_rst", {31'd0, IMEM_REQ}, 32'd1);

        run_instr("addi5",   1, 4, 32'h00000005, 1'b0, 1'b0, 8'd4);
        run_instr("addim1",  1, 4, 32'hFFFFFFFF, 1'b0, 1'b0, 8'd8);
        run_instr("add_neg", 1, 4, 32'hFFFFFFFE, 1'b0, 1'b0, 8'd12);
        run_instr("sltu",    1, 4, 32'h00000000, 1'b0, 1'b1, 8'd16);
        run_instr("addi1",   1, 4, 32'h00000001, 1'b0, 1'b0, 8'd20);
        run_instr("addi31",  1, 4, 32'h0000001F, 1'b0, 1'b0, 8'd24);
        run_instr("sllv",    1, 4, 32'h80000000, 1'b0, 1'b0, 8'd28);
        run_instr("sub_of",  1, 4, 32'h80000000, 1'b1, 1'b0, 8'd32);
        run_instr("addi_r0", 1, 4, 32'h00000007, 1'b0, 1'b0, 8'd36);
        run_instr("add_r0",  1, 4, 32'h00000000, 1'b0, 1'b1, 8'd40);

        IMEM_RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_state", {29'd0, DBG_STATE}, 32'd0);
            check("stall_addr", {24'd0, IMEM_ADDR}, 32'd40);
            check("stall_retire", {31'd0, RETIRE}, 32'd0);
            @(negedge CLK); #1;
        end
        IMEM_RDY = 1'b1;
        run_instr("stall_add", 4, 7, 32'h80000000, 1'b0, 1'b0, 8'd44);
        run_instr("noop",      1, 4, 32'h00000000, 1'b1, 1'b1, 8'd48);
        run_instr("r3_kept",   1, 4, 32'h80000000, 1'b0, 1'b0, 8'd52);

        // Halt: FETCH, DECODE, then HALTED for good
        repeat (2) @(negedge CLK);
        #1;
        for (int i = 0; i < 6; i++) begin
            check("halt_flag", {31'd0, HALT}, 32'd1);
            check("halt_state", {29'd0, DBG_STATE}, 32'd4);
            check("halt_req", {31'd0, IMEM_REQ}, 32'd0);
            check("halt_retire", {31'd0, RETIRE}, 32'd0);
            check("halt_pc", {24'd0, IMEM_ADDR}, 32'd52);
            @(negedge CLK); #1;
        end

        RST_N = 1'b0; #1;
        check("rst2_state", {29'd0, DBG_STATE}, 32'd0);
        check("rst2_halt", {31'd0, HALT}, 32'd0);
        check("rst2_pc", {24'd0, IMEM_ADDR}, 32'd0);
        @(negedge CLK); RST_N = 1'b1; #1;
        run_instr("restart", 1, 4, 32'h00000005, 1'b0, 1'b0, 8'd4);

        // PC wrap on the 4-bit-address core: four addi r1,r1,1
        @(negedge CLK); RST2_N = 1'b1; #1;
        for (int k = 1; k <= 4; k++) begin
            int n;
            n = 0;
            while (RETIRE2 !== 1'b1 && n < 20) begin
                @(negedge CLK); #1;
                n++;
            end
            check("wrap_retire", {31'd0, RETIRE2}, 32'd1);
            check("wrap_out", ALU_OUT2, k);
            @(negedge CLK); #1;
            check("wrap_addr", {28'd0, IMEM_ADDR2}, (k * 4) % 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
